mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL provide: Start  input  1  request to begin the multiply/divide operation selected by MDOp.
REQ-004 SHALL provide: MDOp  input  3  op code: 000 mult, 001 multu, 010 div, 011 divu, 100 msub; other codes ignored.
REQ-005 SHALL provide: A  input  32  rs operand (forwarded value, E stage).
REQ-006 SHALL provide: B  input  32  rt operand (forwarded value, E stage).
REQ-007 SHALL provide: MDWe  input  1  direct write of A to HI or LO (mthi/mtlo).
REQ-008 SHALL provide: HiLo  input  1  direct-write target: 1 = HI, 0 = LO.
REQ-009 SHALL provide: MDOutFin  input  1  read select: 1 = HI, 0 = LO.
REQ-010 SHALL provide: Busy  output  1  operation pending or executing; hazard unit stalls D-stage instructions with MDSignal=1 while Busy=1.
REQ-011 SHALL provide: Out  output  32  HI when MDOutFin=1, else LO (mfhi/mflo result).

Function
REQ-012 SHALL hold internal registers hi, lo (32 bit each), a countdown counter cnt (4 bit), a pending-op register, and latched copies of A and B.
REQ-013 SHALL have two states: IDLE (cnt=0) and RUN (cnt!=0).
REQ-014 SHALL, in IDLE with Start=1 and a valid MDOp at a clock edge, latch A, B and MDOp, then load cnt=5 for mult/multu/msub or cnt=10 for div/divu.
REQ-015 SHALL decrement cnt by 1 on each edge in RUN; on the edge where cnt goes 1->0, write the result to hi/lo and return to IDLE.
REQ-016 SHALL drive Busy = Start | (cnt != 0) combinationally, so that Busy is already high in the cycle Start is asserted.
REQ-017 SHALL ignore Start and MDWe while in RUN; hi/lo remain unchanged until the operation completes.
REQ-018 SHALL, for mult, set {hi,lo} to the signed 64-bit product A*B.
REQ-019 SHALL, for multu, set {hi,lo} to the unsigned 64-bit product A*B.
REQ-020 SHALL, for msub, set {hi,lo} to {hi,lo} minus signed A*B, wrapping modulo 2^64, using hi/lo as they stand at completion.
REQ-021 SHALL, for div, set lo to the quotient truncated toward zero and hi to the remainder, the remainder taking the sign of the dividend.
REQ-022 SHALL, for divu, produce the unsigned quotient in lo and the unsigned remainder in hi.
REQ-023 SHALL, for div with 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0.
REQ-024 SHALL, for div or divu with B=0, leave hi and lo unchanged, while still spending the full 10 Busy cycles.
REQ-025 SHALL, when IDLE and MDWe=1, write A into hi (HiLo=1) or lo (HiLo=0) at the edge; MDWe takes effect in one cycle and does not assert Busy.
REQ-026 SHALL give Start priority if Start and MDWe are both 1 in IDLE: the operation begins and the MDWe write is dropped.
REQ-027 SHALL drive Out combinationally from the current hi/lo registers; there is no bypass of a result being written at the same edge.
REQ-028 SHALL treat Start with an undefined MDOp code as a no-op: no state change, but Busy still follows REQ-016 for that cycle.

Reset
REQ-029 SHALL, on reset=1, asynchronously clear hi, lo, cnt, the latched operands and the pending op; Busy then reads 0 and Out reads 0.
REQ-030 SHALL abandon any in-flight operation on reset, writing no result to hi/lo.

Structure
REQ-031 SHALL place the MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MSUB) and latency constants (MUL_CYCLES=5, DIV_CYCLES=10) in a shared package, mdu_pkg, which the controller also uses.
REQ-032 SHALL be a single module; the arithmetic is behavioural, and the result is computed from the latched operands at completion. No sub-module is required.

Verification
REQ-033 SHALL verify: mult A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 SHALL verify: div A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with B=0 -> hi/lo unchanged after 10 cycles.
REQ-035 SHALL verify: mthi A=5 then mtlo A=7, then msub A=2, B=3 -> hi=5, lo=1 after 5 cycles; reading back gives Out=5 (MDOutFin=1) and Out=1 (MDOutFin=0).
REQ-036 SHALL verify: Start or MDWe issued at cycle 2 of a running mult -> ignored; final hi/lo match the first op only.
REQ-037 SHALL verify: reset asserted at cycle 3 of a div -> Busy=0 immediately, hi=lo=0, and no result appears later.
REQ-038 SHALL verify: Start and MDWe asserted together in IDLE -> the operation runs and the direct write is discarded.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encodings, latencies and controller state type for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MSUB  = 3'b100;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MSUB);
  endfunction

  function automatic logic [3:0] op_cycles(input logic [2:0] op);
    return ((op == MD_DIV) || (op == MD_DIVU)) ? DIV_CYCLES : MUL_CYCLES;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; operands latched at Start,
// result computed behaviourally from the latched copies on the final countdown edge.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDWe,
  input  logic        HiLo,
  input  logic        MDOutFin,
  output logic        Busy,
  output logic [31:0] Out,
  output mdu_state_e  DbgState
);

  mdu_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_op, w_op_nxt;
  logic [31:0] r_a, w_a_nxt;
  logic [31:0] r_b, w_b_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  logic [63:0] w_sprod, w_uprod, w_msub;
  logic        w_a_neg, w_b_neg, w_b_zero;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe;
  logic [31:0] w_uquo, w_urem, w_squo, w_srem;
  logic [31:0] w_dquo, w_drem;

  assign w_sprod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_uprod = {32'd0, r_a} * {32'd0, r_b};
  assign w_msub  = {r_hi, r_lo} - w_sprod;

  // Signed divide works on magnitudes; 0x80000000 is its own magnitude, so the
  // overflow case naturally yields quotient 0x80000000, remainder 0.
  assign w_a_neg  = r_a[31];
  assign w_b_neg  = r_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_b_zero = (r_b == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : w_b_mag;
  assign w_squo   = w_a_mag / w_b_safe;
  assign w_srem   = w_a_mag % w_b_safe;
  assign w_uquo   = r_a / (w_b_zero ? 32'd1 : r_b);
  assign w_urem   = r_a % (w_b_zero ? 32'd1 : r_b);
  assign w_dquo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_squo) : w_squo;
  assign w_drem   = w_a_neg ? (32'd0 - w_srem) : w_srem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (Start && is_valid_op(MDOp)) begin
          w_op_nxt    = MDOp;
          w_a_nxt     = A;
          w_b_nxt     = B;
          w_cnt_nxt   = op_cycles(MDOp);
          w_state_nxt = ST_RUN;
        end else if (MDWe) begin
          if (HiLo) w_hi_nxt = A;
          else      w_lo_nxt = A;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
          case (r_op)
            MD_MULT:  {w_hi_nxt, w_lo_nxt} = w_sprod;
            MD_MULTU: {w_hi_nxt, w_lo_nxt} = w_uprod;
            MD_MSUB:  {w_hi_nxt, w_lo_nxt} = w_msub;
            MD_DIV: if (!w_b_zero) begin
              w_lo_nxt = w_dquo;
              w_hi_nxt = w_drem;
            end
            MD_DIVU: if (!w_b_zero) begin
              w_lo_nxt = w_uquo;
              w_hi_nxt = w_urem;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign Busy     = Start | (r_cnt != 4'd0);
  assign Out      = MDOutFin ? r_hi : r_lo;
  assign DbgState = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDWe;
  logic        HiLo;
  logic        MDOutFin;
  logic        Busy;
  logic [31:0] Out;
  mdu_state_e  DbgState;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .MDWe(MDWe), .HiLo(HiLo), .MDOutFin(MDOutFin), .Busy(Busy), .Out(Out),
    .DbgState(DbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: plain 64-bit arithmetic on HI/LO
  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0]     p;
    case (op)
      3'b000: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'b001: begin p = ua * ub; {m_hi, m_lo} = p; end
      3'b100: begin p = {m_hi, m_lo} - 64'(sa * sb); {m_hi, m_lo} = p; end
      3'b010: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'b011: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endfunction

  // driver tasks
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_we, output logic start_busy, output int busy_cycles);
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b; MDWe = with_we; HiLo = 1'b1;
    #1 start_busy = Busy;
    @(negedge clk);
    Start = 1'b0; MDWe = 1'b0; A = $urandom; B = $urandom;
    busy_cycles = 0;
    while (Busy && busy_cycles < 30) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic do_mt(input logic hilo, input logic [31:0] val, output logic we_busy);
    @(negedge clk);
    MDWe = 1'b1; HiLo = hilo; A = val;
    #1 we_busy = Busy;
    @(negedge clk);
    MDWe = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MDOutFin = 1'b1; #1 hi = Out;
    MDOutFin = 1'b0; #1 lo = Out;
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    return (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
  endfunction

  // scenarios
  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
    MDWe = 1'b0; HiLo = 1'b0; MDOutFin = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_hilo(hi, lo);
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo);
    end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    logic sb; int bc; logic [31:0] hi, lo;
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, sb, bc);
    n_checks++;
    if (sb !== 1'b1) begin n_fail++; $display("FAIL mult_start_busy got=%b exp=1", sb); end
    n_checks++;
    if (bc != 5) begin n_fail++; $display("FAIL mult_cycles got=%0d exp=5", bc); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_result got=%h/%h exp=ffffffff/fffffffa", hi, lo);
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
  endtask

  task automatic test_div();
    logic sb; int bc; logic [31:0] hi, lo;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, sb, bc);
    n_checks++;
    if (bc != 10) begin n_fail++; $display("FAIL div_cycles got=%0d exp=10", bc); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_result got=%h/%h exp=ffffffff/fffffffd", hi, lo);
    end
    run_op(MD_DIVU, 32'd1234, 32'd0, 1'b0, sb, bc);
    n_checks++;
    if (bc != 10) begin n_fail++; $display("FAIL divu_zero_cycles got=%0d exp=10", bc); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL divu_zero_unchanged got=%h/%h exp=ffffffff/fffffffd", hi, lo);
    end
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, sb, bc);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'h80000000;
  endtask

  task automatic test_msub();
    logic sb, wb; int bc; logic [31:0] hi, lo;
    do_mt(1'b1, 32'd5, wb);
    n_checks++;
    if (wb !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got=%b exp=0", wb); end
    do_mt(1'b0, 32'd7, wb);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd5 || lo !== 32'd7) begin
      n_fail++; $display("FAIL mthi_mtlo got=%h/%h exp=5/7", hi, lo);
    end
    run_op(MD_MSUB, 32'd2, 32'd3, 1'b0, sb, bc);
    n_checks++;
    if (bc != 5) begin n_fail++; $display("FAIL msub_cycles got=%0d exp=5", bc); end
    MDOutFin = 1'b1; #1 hi = Out;
    n_checks++;
    if (hi !== 32'd5) begin n_fail++; $display("FAIL msub_out_hi got=%h exp=5", hi); end
    MDOutFin = 1'b0; #1 lo = Out;
    n_checks++;
    if (lo !== 32'd1) begin n_fail++; $display("FAIL msub_out_lo got=%h exp=1", lo); end
    m_hi = 32'd5; m_lo = 32'd1;
  endtask

  task automatic test_ignore_in_run();
    int bc; logic [31:0] hi, lo;
    @(negedge clk);
    Start = 1'b1; MDOp = MD_MULT; A = 32'd1000; B = 32'd77;
    @(negedge clk);
    Start = 1'b0; A = 32'hDEADBEEF; B = 32'd5;
    @(negedge clk);
    Start = 1'b1; MDOp = MD_DIVU; MDWe = 1'b1; HiLo = 1'b0;
    @(negedge clk);
    Start = 1'b0; MDWe = 1'b0;
    bc = 0;
    while (Busy && bc < 30) begin bc++; @(negedge clk); end
    n_checks++;
    if (bc != 3) begin n_fail++; $display("FAIL ignore_run_cycles got=%0d exp=3", bc); end
    model_apply(MD_MULT, 32'd1000, 32'd77);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("FAIL ignore_run_result got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_midop();
    logic wb; logic [31:0] hi, lo; int busy_seen;
    do_mt(1'b1, 32'h1111, wb);
    @(negedge clk);
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 read_hilo(hi, lo);
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", Busy); end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_hilo got=%h/%h exp=0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Busy) busy_seen++;
    end
    read_hilo(hi, lo);
    n_checks++;
    if (busy_seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_after got=busy%0d %h/%h exp=busy0 0/0", busy_seen, hi, lo);
    end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_start_mdwe();
    logic sb; int bc; logic [31:0] hi, lo;
    run_op(MD_MULTU, 32'h1234, 32'd2, 1'b1, sb, bc);
    model_apply(MD_MULTU, 32'h1234, 32'd2);
    read_hilo(hi, lo);
    n_checks++;
    if (bc != 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("FAIL start_mdwe got=%0d %h/%h exp=5 %h/%h", bc, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_invalid_op();
    logic [31:0] hi, lo; logic b0, b1;
    @(negedge clk);
    Start = 1'b1; MDOp = 3'b110; A = 32'hABCD; B = 32'd3;
    #1 b0 = Busy;
    @(negedge clk);
    Start = 1'b0;
    #1 b1 = Busy;
    read_hilo(hi, lo);
    n_checks++;
    if (b0 !== 1'b1 || b1 !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("FAIL invalid_op got=%b%b %h/%h exp=10 %h/%h", b0, b1, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    logic sb, wb; int bc; logic [31:0] hi, lo, a, b; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      op = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 9));
      if (op == 3'd5) begin
        op = 3'($urandom_range(0, 1));
        do_mt(op[0], a, wb);
        if (op[0]) m_hi = a; else m_lo = a;
        read_hilo(hi, lo);
        n_checks++;
        if (wb !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
          n_fail++; $display("FAIL rand_mt[%0d] got=%b %h/%h exp=0 %h/%h", i, wb, hi, lo, m_hi, m_lo);
        end
      end else begin
        run_op(op, a, b, 1'b0, sb, bc);
        model_apply(op, a, b);
        read_hilo(hi, lo);
        n_checks++;
        if (sb !== 1'b1 || bc != exp_cycles(op) || hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL rand_op[%0d] op=%0d a=%h b=%h got=%b/%0d %h/%h exp=1/%0d %h/%h",
                   i, op, a, b, sb, bc, hi, lo, exp_cycles(op), m_hi, m_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_msub();
    test_ignore_in_run();
    test_reset_midop();
    test_start_mdwe();
    test_invalid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
